// File: rtl/button_seq_lock_pkg.sv
// Shared types and helpers for the button sequence lock.
// Lock state encoding and code-entry extraction.
package button_seq_lock_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    UNLOCKED,
    LOCKOUT
  } lock_state_t;

  localparam int CODE_MAX = 64;
  localparam int ENT_W    = 8;

  function automatic logic [ENT_W-1:0] code_entry(
    input logic [CODE_MAX-1:0] code,
    input int                  k,
    input int                  idx_w
  );
    logic [CODE_MAX-1:0] sh;
    logic [ENT_W-1:0]    e;
    sh = code >> (k * idx_w);
    e  = '0;
    for (int i = 0; i < ENT_W; i++) begin
      if (i < idx_w) e[i] = sh[i];
    end
    return e;
  endfunction

endpackage

// File: rtl/button_seq_lock_if.sv
// Board-side bundle of the button sequence lock.
// master drives buttons/code, slave drives status.
interface button_seq_lock_if #(
  parameter int NUM_BTN = 3,
  parameter int SEQ_LEN = 5
);
  localparam int IDX_W = $clog2(NUM_BTN);
  localparam int PRG_W = $clog2(SEQ_LEN + 1);

  logic [NUM_BTN-1:0]       BTN;
  logic [SEQ_LEN*IDX_W-1:0] SEQ_CODE;
  logic                     LED;
  logic [PRG_W-1:0]         PROGRESS;
  logic                     ERR;
  logic                     LOCKED_OUT;

  modport master (
    output BTN, SEQ_CODE,
    input  LED, PROGRESS, ERR, LOCKED_OUT
  );

  modport slave (
    input  BTN, SEQ_CODE,
    output LED, PROGRESS, ERR, LOCKED_OUT
  );
endinterface

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer plus previous-value flop.
// rise flags a 0->1 transition of each synced button.
module btn_edge_sync #(
  parameter int W = 3
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] btn,
  output logic [W-1:0] rise
);
  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] prev;

  // synchronize raw buttons and remember last synced value
  always_ff @(posedge CLK) begin
    if (!RST) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise = s2 & ~prev;
endmodule

// File: rtl/button_seq_lock.sv
// Push-button sequence lock with timeout and lockout.
// Presses come from btn_edge_sync; outputs are registered.
module button_seq_lock
  import button_seq_lock_pkg::*;
#(
  parameter int NUM_BTN     = 3,
  parameter int SEQ_LEN     = 5,
  parameter int TIMEOUT_CYC = 1000,
  parameter int UNLOCK_CYC  = 500,
  parameter int MAX_ERR     = 3,
  parameter int LOCKOUT_CYC = 2000
) (
  input logic               CLK,
  input logic               RST,
  button_seq_lock_if.slave  bus
);
  localparam int IDX_W  = $clog2(NUM_BTN);
  localparam int CODE_W = SEQ_LEN * IDX_W;
  localparam int PRG_W  = $clog2(SEQ_LEN + 1);
  localparam int ERR_W  = $clog2(MAX_ERR + 1);
  localparam int T_A    = (TIMEOUT_CYC > UNLOCK_CYC) ?
                          TIMEOUT_CYC : UNLOCK_CYC;
  localparam int T_MAX  = (T_A > LOCKOUT_CYC) ? T_A : LOCKOUT_CYC;
  localparam int TMR_W  = $clog2(T_MAX + 1);

  localparam logic [TMR_W-1:0] TO_LIM  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] UL_LIM  = TMR_W'(UNLOCK_CYC - 1);
  localparam logic [TMR_W-1:0] LO_LIM  = TMR_W'(LOCKOUT_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_TOP = TMR_W'(T_MAX);

  logic [NUM_BTN-1:0]  rise;
  lock_state_t         state_q, state_d;
  logic [PRG_W-1:0]    prog_q, prog_d;
  logic [ERR_W-1:0]    errc_q, errc_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                fail_q, fail_d;
  logic [CODE_MAX-1:0] code_ext;
  logic [ENT_W-1:0]    press_idx;
  logic [ENT_W-1:0]    want_idx;
  logic                press;
  logic                match;
  logic                led_d;
  logic                lo_d;

  btn_edge_sync #(.W(NUM_BTN)) u_sync (
    .CLK  (CLK),
    .RST  (RST),
    .btn  (bus.BTN),
    .rise (rise)
  );

  // decode the press and compare it with the expected entry
  always_comb begin
    code_ext = '0;
    code_ext[CODE_W-1:0] = bus.SEQ_CODE;
    press_idx = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (rise[i]) press_idx = ENT_W'(i);
    end
    want_idx = code_entry(code_ext, int'(prog_q), IDX_W);
    press    = |rise;
    match    = $onehot(rise) && (press_idx == want_idx);
  end

  // state, progress, error count and shared timer
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      prog_q  <= '0;
      errc_q  <= '0;
      tmr_q   <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      errc_q  <= errc_d;
      tmr_q   <= tmr_d;
      fail_q  <= fail_d;
    end
  end

  // next state; a failure overrides any restart
  always_comb begin
    state_d = state_q;
    prog_d  = prog_q;
    errc_d  = errc_q;
    fail_d  = 1'b0;
    tmr_d   = (tmr_q == TMR_TOP) ? tmr_q : tmr_q + TMR_W'(1);
    unique case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (press) begin
          if (!match) begin
            fail_d = 1'b1;
          end else if (SEQ_LEN == 1) begin
            state_d = UNLOCKED;
            errc_d  = '0;
          end else begin
            state_d = ENTRY;
            prog_d  = PRG_W'(1);
          end
        end
      end
      ENTRY: begin
        if (press) begin
          if (!match) begin
            fail_d = 1'b1;
          end else begin
            tmr_d = '0;
            if (prog_q == PRG_W'(SEQ_LEN - 1)) begin
              state_d = UNLOCKED;
              prog_d  = '0;
              errc_d  = '0;
            end else begin
              prog_d = prog_q + PRG_W'(1);
            end
          end
        end else if (tmr_q >= TO_LIM) begin
          fail_d = 1'b1;
        end
      end
      UNLOCKED: begin
        if (press || tmr_q >= UL_LIM) state_d = IDLE;
      end
      LOCKOUT: begin
        if (tmr_q >= LO_LIM) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (fail_d) begin
      prog_d = '0;
      tmr_d  = '0;
      if (errc_q == ERR_W'(MAX_ERR - 1)) begin
        state_d = LOCKOUT;
        errc_d  = '0;
      end else begin
        state_d = IDLE;
        errc_d  = errc_q + ERR_W'(1);
      end
    end
  end

  // status levels decoded from the current state
  always_comb begin
    led_d = (state_q == UNLOCKED);
    lo_d  = (state_q == LOCKOUT);
  end

  // glitch-free registered outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      bus.LED        <= 1'b0;
      bus.PROGRESS   <= '0;
      bus.ERR        <= 1'b0;
      bus.LOCKED_OUT <= 1'b0;
    end else begin
      bus.LED        <= led_d;
      bus.PROGRESS   <= prog_q;
      bus.ERR        <= fail_q;
      bus.LOCKED_OUT <= lo_d;
    end
  end
endmodule

// File: tb/tb_button_seq_lock.sv
// Directed bench for button_seq_lock.
// Code C,C,B,B,B; short timers for quick runs.
module tb_button_seq_lock;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  button_seq_lock_if #(.NUM_BTN(3), .SEQ_LEN(5)) bus ();

  button_seq_lock #(
    .NUM_BTN(3), .SEQ_LEN(5), .TIMEOUT_CYC(20),
    .UNLOCK_CYC(10), .MAX_ERR(3), .LOCKOUT_CYC(30)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tap_mask(input logic [2:0] m);
    bus.BTN = m;
    tick(1);
    bus.BTN = '0;
    tick(3);
  endtask

  task automatic tap(input int b);
    logic [2:0] m;
    m = '0;
    m[b] = 1'b1;
    tap_mask(m);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.BTN = '0;
    tick(1);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic enter_code();
    tap(2); tick(1);
    tap(2); tick(1);
    tap(1); tick(1);
    tap(1); tick(1);
    tap(1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.BTN = '0;
    bus.SEQ_CODE = {2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
    tick(3);
    chk("rst_led", 32'(bus.LED), 0);
    chk("rst_prog", 32'(bus.PROGRESS), 0);
    chk("rst_err", 32'(bus.ERR), 0);
    chk("rst_lo", 32'(bus.LOCKED_OUT), 0);
    rst = 1'b1;
    tick(2);

    tap(2); chk("t1_p1", 32'(bus.PROGRESS), 1); tick(1);
    tap(2); chk("t1_p2", 32'(bus.PROGRESS), 2); tick(1);
    tap(1); chk("t1_p3", 32'(bus.PROGRESS), 3); tick(1);
    tap(1); chk("t1_p4", 32'(bus.PROGRESS), 4); tick(1);
    tap(1);
    chk("t1_led_on", 32'(bus.LED), 1);
    chk("t1_p0", 32'(bus.PROGRESS), 0);
    chk("t1_err", 32'(bus.ERR), 0);
    tick(9);
    chk("t1_led_hold", 32'(bus.LED), 1);
    tick(1);
    chk("t1_led_off", 32'(bus.LED), 0);

    do_reset();
    bus.BTN = 3'b100;
    tick(4);
    chk("t2_p1", 32'(bus.PROGRESS), 1);
    tick(11);
    chk("t2_held_p1", 32'(bus.PROGRESS), 1);
    chk("t2_held_err", 32'(bus.ERR), 0);
    bus.BTN = 3'b010;
    tick(1);
    bus.BTN = '0;
    tick(3);
    chk("t2_err", 32'(bus.ERR), 1);
    chk("t2_p0", 32'(bus.PROGRESS), 0);
    tick(1);
    chk("t2_err_pulse", 32'(bus.ERR), 0);

    do_reset();
    tap(2); tick(1);
    tap(2);
    chk("t3_p2", 32'(bus.PROGRESS), 2);
    tick(19);
    chk("t3_pre_err", 32'(bus.ERR), 0);
    chk("t3_pre_p", 32'(bus.PROGRESS), 2);
    tick(1);
    chk("t3_to_err", 32'(bus.ERR), 1);
    chk("t3_to_p0", 32'(bus.PROGRESS), 0);
    chk("t3_led", 32'(bus.LED), 0);
    tick(1);
    chk("t3_err_end", 32'(bus.ERR), 0);
    tick(4);

    do_reset();
    tap(0);
    chk("t4_e1", 32'(bus.ERR), 1);
    chk("t4_lo1", 32'(bus.LOCKED_OUT), 0);
    tick(1);
    tap(0);
    chk("t4_e2", 32'(bus.ERR), 1);
    chk("t4_lo2", 32'(bus.LOCKED_OUT), 0);
    tick(1);
    tap(0);
    chk("t4_e3", 32'(bus.ERR), 1);
    chk("t4_lo3", 32'(bus.LOCKED_OUT), 1);
    tap(2); chk("t4_ign1", 32'(bus.PROGRESS), 0);
    tap(2); chk("t4_ign2", 32'(bus.PROGRESS), 0);
    tap(1); chk("t4_ign3", 32'(bus.PROGRESS), 0);
    tap(1); chk("t4_ign4", 32'(bus.PROGRESS), 0);
    tap(1);
    chk("t4_ign_led", 32'(bus.LED), 0);
    chk("t4_ign_err", 32'(bus.ERR), 0);
    tick(9);
    chk("t4_lo_hold", 32'(bus.LOCKED_OUT), 1);
    tick(1);
    chk("t4_lo_end", 32'(bus.LOCKED_OUT), 0);
    tap(2);
    chk("t4_after_p1", 32'(bus.PROGRESS), 1);

    do_reset();
    tap_mask(3'b101);
    chk("t5_multi_err", 32'(bus.ERR), 1);
    chk("t5_multi_p0", 32'(bus.PROGRESS), 0);
    tick(1);
    tap(2); tick(1);
    tap(2); tick(1);
    tap(1);
    chk("t5_p3", 32'(bus.PROGRESS), 3);
    rst = 1'b0;
    tick(1);
    chk("t5_rst_p", 32'(bus.PROGRESS), 0);
    chk("t5_rst_led", 32'(bus.LED), 0);
    chk("t5_rst_err", 32'(bus.ERR), 0);
    chk("t5_rst_lo", 32'(bus.LOCKED_OUT), 0);
    rst = 1'b1;
    tick(1);
    tap(1);
    chk("t5_restart_err", 32'(bus.ERR), 1);
    chk("t5_restart_p", 32'(bus.PROGRESS), 0);

    do_reset();
    enter_code();
    chk("t6_led_on", 32'(bus.LED), 1);
    tick(3);
    bus.BTN = 3'b001;
    tick(1);
    bus.BTN = '0;
    tick(2);
    chk("t6_led_still", 32'(bus.LED), 1);
    tick(1);
    chk("t6_relock_led", 32'(bus.LED), 0);
    chk("t6_relock_err", 32'(bus.ERR), 0);
    tap(2);
    chk("t6_idle_p1", 32'(bus.PROGRESS), 1);
    chk("t6_idle_lo", 32'(bus.LOCKED_OUT), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
